// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the AES core scheduler.
//   sched_state_t : scheduler FSM states
//   N_REQ         : number of requester ports sharing the core
//   AES_W         : AES block / key width
//   zero_unless() : returns the data word when enabled, otherwise all zeros
package aes_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        BUSY = 2'd2,
        RESP = 2'd3
    } sched_state_t;

    localparam int N_REQ = 2;
    localparam int AES_W = 128;

    // Response lanes of the non-owning port must read as zero.
    function automatic logic [AES_W-1:0] zero_unless(input logic en, input logic [AES_W-1:0] data);
        logic [AES_W-1:0] res;
        if (en) begin
            res = data;
        end else begin
            res = {AES_W{1'b0}};
        end
        return res;
    endfunction

endpackage

// File: rtl/aes_rr_arbiter.sv
// Two-way round-robin grant, purely combinational.
//   valid[1:0] : request lines
//   prio       : port that wins when both are valid
//   gnt        : granted port index (equals prio when nothing is valid)
//   gnt_any    : at least one request is valid
module aes_rr_arbiter
    import aes_ctrl_pkg::*;
(
    input  logic [N_REQ-1:0] valid,
    input  logic             prio,
    output logic             gnt,
    output logic             gnt_any
);

    // Priority port first, otherwise the other port.
    always_comb begin
        gnt     = prio;
        gnt_any = 1'b0;
        if (valid[prio]) begin
            gnt     = prio;
            gnt_any = 1'b1;
        end else if (valid[~prio]) begin
            gnt     = ~prio;
            gnt_any = 1'b1;
        end else begin
            gnt     = prio;
            gnt_any = 1'b0;
        end
    end

endmodule

// File: rtl/aes_core_sched.sv
// Shares one AES-128 encryption core between two requesters.
// Requests are arbitrated round-robin, loaded into the core with a one-cycle
// strobe, and the result (or a watchdog error) is returned to the owning
// requester on a valid/ready response channel.
//   clk, rst                  : clock, synchronous active-low reset
//   reqN_valid/ready/key/text : request channel of port N
//   rspN_valid/ready/data/err : response channel of port N
//   core_ld/key/text          : load strobe and operands to the core
//   core_done/text_out        : completion pulse and result from the core
//   busy                      : scheduler not idle
//   owner                     : port currently (or last) served
module aes_core_sched
    import aes_ctrl_pkg::*;
#(
    parameter  int TIMEOUT = 31,
    localparam int TW      = $clog2(TIMEOUT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [AES_W-1:0] req0_key,
    input  logic [AES_W-1:0] req0_text,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [AES_W-1:0] req1_key,
    input  logic [AES_W-1:0] req1_text,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [AES_W-1:0] rsp0_data,
    output logic             rsp0_err,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [AES_W-1:0] rsp1_data,
    output logic             rsp1_err,
    output logic             core_ld,
    output logic [AES_W-1:0] core_key,
    output logic [AES_W-1:0] core_text,
    input  logic             core_done,
    input  logic [AES_W-1:0] core_text_out,
    output logic             busy,
    output logic             owner
);

    localparam logic [TW-1:0] TIMEOUT_W = TW'(TIMEOUT);

    sched_state_t     state_r, state_n;
    logic             prio_r, prio_n;
    logic             owner_r, owner_n;
    logic [TW-1:0]    wd_r, wd_n;
    logic [TW-1:0]    wd_inc_s;
    logic [AES_W-1:0] key_r, key_n;
    logic [AES_W-1:0] text_r, text_n;
    logic [AES_W-1:0] res_r, res_n;
    logic             err_r, err_n;

    logic             core_ld_r, core_ld_n;
    logic             busy_r, busy_n;
    logic [1:0]       rsp_valid_r, rsp_valid_n;
    logic [1:0]       rsp_err_r, rsp_err_n;
    logic [AES_W-1:0] rsp0_data_r, rsp0_data_n;
    logic [AES_W-1:0] rsp1_data_r, rsp1_data_n;

    logic             gnt_s;
    logic             gnt_any_s;
    logic             rsp_ready_own_s;

    aes_rr_arbiter u_arb (
        .valid   ({req1_valid, req0_valid}),
        .prio    (prio_r),
        .gnt     (gnt_s),
        .gnt_any (gnt_any_s)
    );

    // Ready is the only combinational output; it is withheld while reset is
    // asserted so no handshake can be seen by a requester during reset.
    assign req0_ready = rst && (state_r == IDLE) && gnt_any_s && !gnt_s;
    assign req1_ready = rst && (state_r == IDLE) && gnt_any_s &&  gnt_s;

    assign rsp_ready_own_s = owner_r ? rsp1_ready : rsp0_ready;
    assign wd_inc_s        = wd_r + TW'(1);

    // Next-state and datapath register updates of the scheduler FSM.
    always_comb begin
        state_n = state_r;
        prio_n  = prio_r;
        owner_n = owner_r;
        wd_n    = wd_r;
        key_n   = key_r;
        text_n  = text_r;
        res_n   = res_r;
        err_n   = err_r;
        case (state_r)
            IDLE: begin
                if (gnt_any_s) begin
                    key_n   = gnt_s ? req1_key  : req0_key;
                    text_n  = gnt_s ? req1_text : req0_text;
                    owner_n = gnt_s;
                    state_n = LOAD;
                end else begin
                    state_n = IDLE;
                end
            end
            LOAD: begin
                wd_n    = {TW{1'b0}};
                state_n = BUSY;
            end
            BUSY: begin
                // A completion in the same cycle as the timeout beats it.
                if (core_done) begin
                    res_n   = core_text_out;
                    err_n   = 1'b0;
                    state_n = RESP;
                end else if (wd_inc_s == TIMEOUT_W) begin
                    wd_n    = wd_inc_s;
                    res_n   = {AES_W{1'b0}};
                    err_n   = 1'b1;
                    state_n = RESP;
                end else begin
                    wd_n    = wd_inc_s;
                    state_n = BUSY;
                end
            end
            RESP: begin
                if (rsp_ready_own_s) begin
                    prio_n  = ~owner_r;
                    state_n = IDLE;
                end else begin
                    state_n = RESP;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Output register next values, derived from the state being entered so
    // that every output lines up with its state without a cycle of lag.
    always_comb begin
        core_ld_n   = (state_n == LOAD);
        busy_n      = (state_n != IDLE);
        rsp_valid_n = 2'b00;
        if (state_n == RESP) begin
            rsp_valid_n[owner_n] = 1'b1;
        end else begin
            rsp_valid_n = 2'b00;
        end
        rsp0_data_n  = zero_unless(rsp_valid_n[0], res_n);
        rsp1_data_n  = zero_unless(rsp_valid_n[1], res_n);
        rsp_err_n[0] = rsp_valid_n[0] & err_n;
        rsp_err_n[1] = rsp_valid_n[1] & err_n;
    end

    // State, datapath and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= IDLE;
            prio_r      <= 1'b0;
            owner_r     <= 1'b0;
            wd_r        <= {TW{1'b0}};
            key_r       <= {AES_W{1'b0}};
            text_r      <= {AES_W{1'b0}};
            res_r       <= {AES_W{1'b0}};
            err_r       <= 1'b0;
            core_ld_r   <= 1'b0;
            busy_r      <= 1'b0;
            rsp_valid_r <= 2'b00;
            rsp_err_r   <= 2'b00;
            rsp0_data_r <= {AES_W{1'b0}};
            rsp1_data_r <= {AES_W{1'b0}};
        end else begin
            state_r     <= state_n;
            prio_r      <= prio_n;
            owner_r     <= owner_n;
            wd_r        <= wd_n;
            key_r       <= key_n;
            text_r      <= text_n;
            res_r       <= res_n;
            err_r       <= err_n;
            core_ld_r   <= core_ld_n;
            busy_r      <= busy_n;
            rsp_valid_r <= rsp_valid_n;
            rsp_err_r   <= rsp_err_n;
            rsp0_data_r <= rsp0_data_n;
            rsp1_data_r <= rsp1_data_n;
        end
    end

    assign core_ld    = core_ld_r;
    assign core_key   = key_r;
    assign core_text  = text_r;
    assign busy       = busy_r;
    assign owner      = owner_r;
    assign rsp0_valid = rsp_valid_r[0];
    assign rsp1_valid = rsp_valid_r[1];
    assign rsp0_err   = rsp_err_r[0];
    assign rsp1_err   = rsp_err_r[1];
    assign rsp0_data  = rsp0_data_r;
    assign rsp1_data  = rsp1_data_r;

endmodule

// File: tb/tb_aes_core_sched.sv
// Bench for aes_core_sched with a stub core whose latency is chosen per
// request (0 = never completes). A transaction-level model predicts, for
// every cycle, ready, load strobe, busy/owner and the response lanes.
module tb_aes_core_sched;

    localparam int TO = 5;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [1:0]   hv  = 2'b00;
    logic [127:0] hk [2];
    logic [127:0] ht [2];
    int           hl [2];
    logic [1:0]   rr  = 2'b00;
    logic         core_done = 1'b0;
    logic [127:0] core_text_out = 128'd0;

    wire          req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
    wire          core_ld, busy, owner;
    wire [127:0]  rsp0_data, rsp1_data, core_key, core_text;

    aes_core_sched #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(hv[0]), .req0_ready(req0_ready), .req0_key(hk[0]), .req0_text(ht[0]),
        .req1_valid(hv[1]), .req1_ready(req1_ready), .req1_key(hk[1]), .req1_text(ht[1]),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rr[0]), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rr[1]), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
        .core_ld(core_ld), .core_key(core_key), .core_text(core_text),
        .core_done(core_done), .core_text_out(core_text_out),
        .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // model state
    logic         m_busy = 1'b0, m_port = 1'b0, m_prio = 1'b0, m_owner = 1'b0, m_err = 1'b0;
    int           m_t = 0, m_v = 0;
    logic [127:0] m_key, m_text, m_data;
    logic         just_rst = 1'b0;
    int           acc_cyc [2];
    int           rise_cyc [2];
    logic [127:0] last_obs [2];
    logic [1:0]   prev_v = 2'b00;
    logic         glog [$];

    // stub core state
    int           stub_lat = 0;
    int           s_cnt = 0;
    logic [127:0] s_key = 128'd0, s_text = 128'd0;
    logic         spur = 1'b0;

    function automatic logic [127:0] fake_aes(input logic [127:0] k, input logic [127:0] t);
        logic [127:0] r;
        if (k == FIPS_KEY && t == FIPS_PT) r = FIPS_CT;
        else r = k ^ {t[63:0], t[127:64]} ^ 128'h5a5a_3c3c_0f0f_a5a5_c3c3_f0f0_1234_5678;
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Stub core: completes `stub_lat` cycles after the load strobe; result
    // bus carries noise outside the done cycle.
    always @(negedge clk) begin
        core_done     = 1'b0;
        core_text_out = rnd128();
        if (spur) core_done = 1'b1;
        if (core_ld) begin
            s_cnt  = stub_lat;
            s_key  = core_key;
            s_text = core_text;
        end else if (s_cnt > 0) begin
            s_cnt = s_cnt - 1;
            if (s_cnt == 0) begin
                core_done     = 1'b1;
                core_text_out = fake_aes(s_key, s_text);
            end
        end
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0b expected=%0b", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic post(input logic p, input logic [127:0] k, input logic [127:0] t, input int lat);
        hk[p] = k;
        ht[p] = t;
        hl[p] = lat;
        hv[p] = 1'b1;
    endtask

    // One clock cycle: check ready, advance, update the model, check outputs.
    task automatic step();
        logic       g_ok, g, hs, ev0, ev1;
        logic [1:0] exp_rdy;
        #1;
        g_ok    = 1'b0;
        g       = 1'b0;
        exp_rdy = 2'b00;
        if (rst && !m_busy) begin
            if (hv[m_prio]) begin
                g_ok = 1'b1; g = m_prio;
            end else if (hv[~m_prio]) begin
                g_ok = 1'b1; g = ~m_prio;
            end
        end
        if (g_ok) exp_rdy[g] = 1'b1;
        chk1("req0_ready", req0_ready, exp_rdy[0]);
        chk1("req1_ready", req1_ready, exp_rdy[1]);
        hs = rst && m_busy && (cyc >= m_v) && rr[m_port];
        if (hs) last_obs[m_port] = m_port ? rsp1_data : rsp0_data;
        prev_v = {rsp1_valid, rsp0_valid};

        @(posedge clk);
        #1;
        cyc++;
        just_rst = 1'b0;
        if (!rst) begin
            m_busy = 1'b0; m_prio = 1'b0; m_owner = 1'b0; just_rst = 1'b1;
        end else if (hs) begin
            m_busy = 1'b0;
            m_prio = ~m_port;
        end else if (g_ok) begin
            m_busy   = 1'b1;
            m_port   = g;
            m_owner  = g;
            m_t      = cyc - 1;
            m_v      = m_t + 2 + ((hl[g] == 0) ? TO : hl[g]);
            m_key    = hk[g];
            m_text   = ht[g];
            m_err    = (hl[g] == 0);
            m_data   = m_err ? 128'd0 : fake_aes(hk[g], ht[g]);
            stub_lat = hl[g];
            hv[g]    = 1'b0;
            acc_cyc[g] = m_t;
            glog.push_back(g);
        end

        chk1("busy", busy, m_busy);
        chk1("owner", owner, m_owner);
        chk1("core_ld", core_ld, m_busy && (cyc == m_t + 1));
        if (m_busy && (cyc == m_t + 1)) begin
            chk128("core_key", core_key, m_key);
            chk128("core_text", core_text, m_text);
        end
        if (just_rst) begin
            chk128("rst_core_key", core_key, 128'd0);
            chk128("rst_core_text", core_text, 128'd0);
        end
        ev0 = m_busy && !m_port && (cyc >= m_v);
        ev1 = m_busy &&  m_port && (cyc >= m_v);
        chk1("rsp0_valid", rsp0_valid, ev0);
        chk128("rsp0_data", rsp0_data, ev0 ? m_data : 128'd0);
        chk1("rsp0_err", rsp0_err, ev0 && m_err);
        chk1("rsp1_valid", rsp1_valid, ev1);
        chk128("rsp1_data", rsp1_data, ev1 ? m_data : 128'd0);
        chk1("rsp1_err", rsp1_err, ev1 && m_err);
        if (rsp0_valid && !prev_v[0]) rise_cyc[0] = cyc;
        if (rsp1_valid && !prev_v[1]) rise_cyc[1] = cyc;
    endtask

    task automatic wait_acc(input logic p);
        int n = 0;
        while (hv[p] && n < 40) begin step(); n++; end
        chk1("acc_wait", hv[p], 1'b0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (m_busy && n < 60) begin step(); n++; end
        chk1("idle_wait", m_busy, 1'b0);
    endtask

    task automatic wait_rsp(input logic p);
        int n = 0;
        while (!(p ? rsp1_valid : rsp0_valid) && n < 20) begin step(); n++; end
        chk1("rsp_wait", p ? rsp1_valid : rsp0_valid, 1'b1);
    endtask

    initial begin
        logic [127:0] k, t;
        hk[0] = 128'd0; hk[1] = 128'd0; ht[0] = 128'd0; ht[1] = 128'd0;
        hl[0] = 1; hl[1] = 1;
        acc_cyc[0] = 0; acc_cyc[1] = 0; rise_cyc[0] = 0; rise_cyc[1] = 0;
        last_obs[0] = 128'd0; last_obs[1] = 128'd0;

        // reset
        rst = 1'b0;
        step(); step();
        rst = 1'b1;
        step();

        // FIPS-197 vector on port 0, core latency 3
        rr = 2'b11;
        post(1'b0, FIPS_KEY, FIPS_PT, 3);
        wait_acc(1'b0);
        chk1("fips_ld", core_ld, 1'b1);
        wait_rsp(1'b0);
        chk_int("fips_rsp_lat", rise_cyc[0] - acc_cyc[0], 5);
        chk128("fips_ct", rsp0_data, FIPS_CT);
        chk1("fips_err", rsp0_err, 1'b0);
        wait_idle();

        // both valid from reset: grants alternate 0,1,0,1
        rst = 1'b0; step(); rst = 1'b1;
        glog.delete();
        for (int n = 0; n < 80 && glog.size() < 4; n++) begin
            if (!hv[0]) post(1'b0, rnd128(), rnd128(), 2);
            if (!hv[1]) post(1'b1, rnd128(), rnd128(), 2);
            step();
        end
        chk_int("alt_count", glog.size(), 4);
        for (int i = 0; i < glog.size() && i < 4; i++) chk1("alt_owner", glog[i], i[0]);
        hv = 2'b00;
        wait_idle();

        // response backpressure on port 1 with req0 pending
        rr = 2'b01;
        post(1'b1, rnd128(), rnd128(), 2);
        wait_acc(1'b1);
        post(1'b0, rnd128(), rnd128(), 2);
        wait_rsp(1'b1);
        for (int i = 0; i < 10; i++) step();
        chk1("bp_req0_held", hv[0], 1'b1);
        chk1("bp_rsp1_valid", rsp1_valid, 1'b1);
        rr = 2'b11;
        wait_acc(1'b0);
        wait_idle();

        // watchdog: core never completes
        post(1'b0, rnd128(), rnd128(), 0);
        wait_acc(1'b0);
        wait_rsp(1'b0);
        chk_int("wd_latency", rise_cyc[0] - acc_cyc[0], 7);
        chk1("wd_err", rsp0_err, 1'b1);
        chk128("wd_data", rsp0_data, 128'd0);
        wait_idle();

        // done on the same cycle the watchdog expires
        k = rnd128(); t = rnd128();
        post(1'b0, k, t, TO);
        wait_acc(1'b0);
        wait_rsp(1'b0);
        chk_int("coll_latency", rise_cyc[0] - acc_cyc[0], 7);
        chk1("coll_err", rsp0_err, 1'b0);
        chk128("coll_data", rsp0_data, fake_aes(k, t));
        wait_idle();

        // spurious done in IDLE and in RESP
        spur = 1'b1; step(); spur = 1'b0; step();
        chk1("spur_idle_busy", busy, 1'b0);
        rr = 2'b00;
        post(1'b0, rnd128(), rnd128(), 1);
        wait_acc(1'b0);
        wait_rsp(1'b0);
        spur = 1'b1; step(); spur = 1'b0; step();
        rr = 2'b11;
        wait_idle();

        // reset in the middle of BUSY drops the operation
        post(1'b0, rnd128(), rnd128(), 4);
        wait_acc(1'b0);
        step();
        chk1("pre_rst_busy", busy, 1'b1);
        rst = 1'b0; step(); rst = 1'b1;
        chk1("rst_busy_clr", busy, 1'b0);
        for (int i = 0; i < 8; i++) step();
        k = rnd128(); t = rnd128();
        post(1'b0, k, t, 2);
        wait_acc(1'b0);
        wait_idle();
        chk128("post_rst_data", last_obs[0], fake_aes(k, t));

        // randomized traffic on both ports
        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (!hv[p] && $urandom_range(0, 3) == 0)
                    post(1'(p), rnd128(), rnd128(), ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 5)));
            end
            rr = 2'($urandom_range(0, 3));
            step();
        end
        rr = 2'b11;
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
